// File: rtl/bm_rng_pkg.sv
// Shared constants and types for the Box-Muller generator and its stats sink.
// Sample format is Q5.11 signed.
package bm_rng_pkg;

   localparam int BM_W = 16;
   localparam int BM_FRAC = 11;
   localparam logic [15:0] BM_THRESH = 16'h1800;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } stats_state_t;

endpackage

// File: rtl/bm_rng_stats_chan.sv
// One channel of the stats sink: abs/square/compare stage, accumulators
// and the result registers that hold between windows.
module bm_rng_stats_chan
   import bm_rng_pkg::*;
#(
   parameter int          W      = BM_W,
   parameter int          FRAC   = BM_FRAC,
   parameter int          LOG2_N = 10,
   parameter logic [15:0] THRESH = BM_THRESH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr,
   input  logic                accept,
   input  logic                fin,
   input  logic signed [W-1:0] x_in,
   output logic        [W-1:0] mean,
   output logic        [W-1:0] msq,
   output logic       [LOG2_N:0] oor
);

   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
   localparam int SW = W + LOG2_N;
   localparam int QW = 2 * W + LOG2_N;
   localparam int SH = FRAC + LOG2_N;

   logic signed [W-1:0]   x_q, x_d;
   logic [2*W-1:0]        sq_q, sq_d;
   logic                  big_q, big_d;
   logic                  vld_q, vld_d;
   logic signed [SW-1:0]  sum_q, sum_d;
   logic [QW-1:0]         ssq_q, ssq_d;
   logic [LOG2_N:0]       cnt_q, cnt_d;
   logic [W-1:0]          mean_q, mean_d;
   logic [W-1:0]          msq_q, msq_d;
   logic [LOG2_N:0]       oor_q, oor_d;
   logic [W-1:0]          mag;
   logic signed [2*W-1:0] prod;

   // -2^(W-1) has no positive twin; clamp it so the compare still fires
   always_comb begin
      if (!x_in[W-1]) mag = x_in;
      else if (x_in == MINV) mag = MAXV;
      else mag = -x_in;
      prod = x_in * x_in;
   end

   always_comb begin
      x_d    = x_in;
      sq_d   = prod;
      big_d  = (mag >= THRESH[W-1:0]);
      vld_d  = accept;
      sum_d  = sum_q;
      ssq_d  = ssq_q;
      cnt_d  = cnt_q;
      mean_d = mean_q;
      msq_d  = msq_q;
      oor_d  = oor_q;
      if (clr) begin
         vld_d = 1'b0;
         sum_d = '0;
         ssq_d = '0;
         cnt_d = '0;
      end else if (vld_q) begin
         sum_d = sum_q + {{LOG2_N{x_q[W-1]}}, x_q};
         ssq_d = ssq_q + {{LOG2_N{1'b0}}, sq_q};
         cnt_d = cnt_q + {{LOG2_N{1'b0}}, big_q};
      end
      if (fin) begin
         mean_d = sum_q[SW-1:LOG2_N];
         if (|ssq_q[QW-1:SH+W]) msq_d = '1;
         else msq_d = ssq_q[SH+W-1:SH];
         oor_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         x_q    <= '0;
         sq_q   <= '0;
         big_q  <= 1'b0;
         vld_q  <= 1'b0;
         sum_q  <= '0;
         ssq_q  <= '0;
         cnt_q  <= '0;
         mean_q <= '0;
         msq_q  <= '0;
         oor_q  <= '0;
      end else begin
         x_q    <= x_d;
         sq_q   <= sq_d;
         big_q  <= big_d;
         vld_q  <= vld_d;
         sum_q  <= sum_d;
         ssq_q  <= ssq_d;
         cnt_q  <= cnt_d;
         mean_q <= mean_d;
         msq_q  <= msq_d;
         oor_q  <= oor_d;
      end
   end

   assign mean = mean_q;
   assign msq  = msq_q;
   assign oor  = oor_q;

endmodule

// File: rtl/bm_rng_stats.sv
// Windowed mean / mean-square / out-of-range statistics over x0/x1 pairs.
// Holds the window FSM, sample counter and busy/done.
module bm_rng_stats
   import bm_rng_pkg::*;
#(
   parameter int          W      = BM_W,
   parameter int          FRAC   = BM_FRAC,
   parameter int          LOG2_N = 10,
   parameter logic [15:0] THRESH = BM_THRESH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                valid,
   input  logic signed [W-1:0] x0_in,
   input  logic signed [W-1:0] x1_in,
   output logic                busy,
   output logic                done,
   output logic        [W-1:0] mean_x0,
   output logic        [W-1:0] mean_x1,
   output logic        [W-1:0] msq_x0,
   output logic        [W-1:0] msq_x1,
   output logic       [LOG2_N:0] oor_x0,
   output logic       [LOG2_N:0] oor_x1
);

   stats_state_t      state_q, state_d;
   logic [LOG2_N-1:0] cnt_q, cnt_d;
   logic              drain_q, drain_d;
   logic              done_q, done_d;
   logic              clr, accept, fin;

   assign clr    = (state_q == ST_IDLE) && start;
   assign accept = (state_q == ST_ACCUM) && valid;
   // DRAIN lasts two cycles: one for stage 1, one for the accumulators
   assign fin    = (state_q == ST_DRAIN) && drain_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      done_d  = fin;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACCUM;
               cnt_d   = '0;
            end
         end
         ST_ACCUM: begin
            if (valid) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_d = ST_DRAIN;
                  drain_d = 1'b0;
               end
            end
         end
         ST_DRAIN: begin
            if (!drain_q) drain_d = 1'b1;
            else state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         drain_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

   bm_rng_stats_chan #(
      .W(W), .FRAC(FRAC), .LOG2_N(LOG2_N), .THRESH(THRESH)
   ) u_ch0 (
      .clk(clk), .reset(reset), .clr(clr), .accept(accept), .fin(fin),
      .x_in(x0_in), .mean(mean_x0), .msq(msq_x0), .oor(oor_x0)
   );

   bm_rng_stats_chan #(
      .W(W), .FRAC(FRAC), .LOG2_N(LOG2_N), .THRESH(THRESH)
   ) u_ch1 (
      .clk(clk), .reset(reset), .clr(clr), .accept(accept), .fin(fin),
      .x_in(x1_in), .mean(mean_x1), .msq(msq_x1), .oor(oor_x1)
   );

endmodule

// File: doc/bm_rng_stats.md
# bm_rng_stats

Statistics sink for the Box-Muller generator output stream. It consumes valid-qualified `x0`/`x1` sample pairs over a window of 2^LOG2_N pairs. For each channel it reports the mean, the mean square and an out-of-range count. It sits directly after `bm_rng` and gives an on-chip quality check of the Gaussian output without golden vectors.

## Interface
- `W`, 16: sample width, signed two's complement.
- `FRAC`, 11: fractional bits of the sample format (Q5.11).
- `LOG2_N`, 10: window length is 2^LOG2_N sample pairs.
- `THRESH`, 16'h1800: out-of-range magnitude threshold (3.0 in Q5.11).

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a window.
- `valid` in 1: `x0_in`/`x1_in` hold a sample pair this cycle.
- `x0_in` in W: channel 0 sample.
- `x1_in` in W: channel 1 sample.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse; results were updated this cycle.
- `mean_x0`, `mean_x1` out W: signed mean.
- `msq_x0`, `msq_x1` out W: unsigned mean square, Q5.11.
- `oor_x0`, `oor_x1` out LOG2_N+1: count of samples with |x| >= THRESH.

## Operation
- States are IDLE, ACCUM, DRAIN.
  - IDLE: `start`=1 goes to ACCUM. It clears the sum, square-sum, oor counters and the sample counter.
  - ACCUM: each `valid` cycle accepts one pair and increments the sample counter. When the 2^LOG2_N-th pair is accepted, the block goes to DRAIN.
  - DRAIN: waits for the pipeline to empty, then pulses `done` and returns to IDLE.
- `valid` in IDLE or DRAIN is ignored. `start` in ACCUM or DRAIN is ignored.
- Per channel pipeline:
  - Stage 1 registers the sample, its square (2W bits) and the compare |x| >= THRESH.
  - Stage 2 adds into the accumulators.
- |x| of -2^(W-1) saturates to 2^(W-1)-1 for the compare only. The square uses the true value.
- Accumulator widths: sum is W+LOG2_N signed, square-sum is 2W+LOG2_N unsigned. Neither can overflow.
- Results at `done`:
  - mean = sum >>> LOG2_N (arithmetic shift, floor).
  - msq = sumsq >> (FRAC+LOG2_N), saturated to 2^W-1.
  - oor = the count.
- Result outputs hold their value until the next `done`. Starting a new window does not disturb them.

## Timing
- Reset (`reset`=0 at a rising edge): state IDLE, `busy`=0, `done`=0, all result outputs 0, accumulators and pipeline valid bits 0.
- `start` sampled high in IDLE at edge t: `busy`=1 from t+1. The first pair can be accepted at t+1.
- Last pair accepted at edge t:
  - Stage 1 at t+1, stage 2 at t+2.
  - `done`=1 and results valid in cycle t+3.
  - `busy`=0 in the same cycle as `done`. A new `start` is accepted at t+3 or later.
- Gaps in `valid` stall accumulation only. There is no timeout.
- Back-to-back `valid` is supported at one pair per cycle.
- Reset mid-window aborts the window. There is no `done`, and the outputs return to 0.

## Structure
- A shared package `bm_rng_pkg` holds:
  - the sample width and FRAC constants, shared with `bm_rng`;
  - the state enum `stats_state_t`;
  - the default THRESH.
- One sub-module, `bm_rng_stats_chan`, instantiated twice. It contains the square/abs/compare stage, the accumulators and the result registers for one channel.
- The top level holds the FSM, the sample counter and the `busy`/`done` logic.

## Test plan
All scenarios use LOG2_N=4 (N=16) unless stated.
- Constant input, 16 pairs of x0=x1=16'h0800: `done` 3 cycles after the last `valid`; mean=16'h0800, msq=16'h0800, oor=0.
- Alternating 16'h0800/16'hF800 on x0, constant 16'h1800 on x1:
  - mean_x0=0, msq_x0=16'h0800, oor_x0=0;
  - mean_x1=16'h1800, msq_x1=16'h4800, oor_x1=16.
- x0=16'h8000 for all 16 pairs: oor_x0=16, mean_x0=16'h8000, msq_x0 saturates to 16'hFFFF.
- `valid` asserted every third cycle, plus `start` pulsed during ACCUM:
  - the second `start` is ignored;
  - `done` comes exactly once, 3 cycles after the 16th `valid`;
  - `busy` stays high throughout;
  - `valid` pulses before `start` are ignored.
- Reset asserted after the 8th pair: no `done`, all outputs 0. A fresh 16-pair window of 16'h0400 then gives mean=16'h0400, msq=16'h0200.
- LOG2_N=10, fed from `bm_rng` (seeds 2796307 / 2464179 / 1406639 / 3028801 / 3736043 / 1348491):
  - |mean| < 16'h0080 (0.0625);
  - msq within 16'h0700..16'h0900;
  - oor <= 8 per channel.
